// File: rtl/axis_frame_arb_len_if.sv
// Bus bundle for axis_frame_arb_len: S_COUNT ingress AXI streams plus the shared egress stream.
// slave is the arbiter's view; master is the traffic side (sources and downstream sink).
interface axis_frame_arb_len_if #(
    parameter int S_COUNT    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int KEEP_WIDTH = (DATA_WIDTH / 8),
    parameter int ID_WIDTH   = $clog2(S_COUNT)
);
    logic [S_COUNT*DATA_WIDTH-1:0] s_axis_tdata;
    logic [S_COUNT*KEEP_WIDTH-1:0] s_axis_tkeep;
    logic [S_COUNT-1:0]            s_axis_tvalid;
    logic [S_COUNT-1:0]            s_axis_tready;
    logic [S_COUNT-1:0]            s_axis_tlast;

    logic [DATA_WIDTH-1:0]         m_axis_tdata;
    logic [KEEP_WIDTH-1:0]         m_axis_tkeep;
    logic                          m_axis_tvalid;
    logic                          m_axis_tready;
    logic                          m_axis_tlast;
    logic [ID_WIDTH-1:0]           m_axis_tid;

    modport slave (
        input  s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast, m_axis_tready,
        output s_axis_tready, m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast, m_axis_tid
    );

    modport master (
        output s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast, m_axis_tready,
        input  s_axis_tready, m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast, m_axis_tid
    );
endinterface

// File: rtl/axis_frame_arb_len.sv
// Frame-level round-robin AXI-stream arbiter that also reports the byte length and source
// of every forwarded frame.
module axis_frame_arb_len #(
    parameter int S_COUNT     = 4,
    parameter int DATA_WIDTH  = 8,
    parameter int KEEP_ENABLE = (DATA_WIDTH > 8),
    parameter int KEEP_WIDTH  = (DATA_WIDTH / 8),
    parameter int LEN_WIDTH   = 16,
    parameter int ID_WIDTH    = $clog2(S_COUNT)
) (
    input  logic                 clk,
    input  logic                 rst,
    axis_frame_arb_len_if.slave  bus,
    output logic [LEN_WIDTH-1:0] frame_len_o,
    output logic [ID_WIDTH-1:0]  frame_len_id_o,
    output logic                 frame_len_valid_o
);

    // state  | meaning
    // IDLE   | outputs quiet, pick next port round-robin from rr_ptr
    // ACTIVE | granted port passes straight through until its tlast transfer
    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] ACTIVE = 1'b1;

    // Sum is wide enough that a single beat can never overflow it before the saturation compare.
    localparam int BYTES_W = $clog2(KEEP_WIDTH + 1);
    localparam int SUM_W   = LEN_WIDTH + BYTES_W + 1;
    localparam logic [SUM_W-1:0] LEN_MAX = {{(SUM_W-LEN_WIDTH){1'b0}}, {LEN_WIDTH{1'b1}}};

    logic [0:0]           state_q, state_d;
    logic [ID_WIDTH-1:0]  grant_q, grant_d;
    logic [ID_WIDTH-1:0]  rr_ptr_q, rr_ptr_d;
    logic [LEN_WIDTH-1:0] len_cnt_q, len_cnt_d;
    logic [LEN_WIDTH-1:0] frame_len_q, frame_len_d;
    logic [ID_WIDTH-1:0]  frame_len_id_q, frame_len_id_d;
    logic                 frame_len_valid_q, frame_len_valid_d;

    logic                 arb_found;
    logic [ID_WIDTH-1:0]  arb_sel;
    logic [KEEP_WIDTH-1:0] g_keep;
    logic                 beat;
    logic [SUM_W-1:0]     beat_bytes;
    logic [SUM_W-1:0]     len_sum;
    logic [LEN_WIDTH-1:0] len_sat;

    always_comb begin
        arb_found = 1'b0;
        arb_sel   = rr_ptr_q;
        for (int k = 0; k < S_COUNT; k++) begin
            if (!arb_found && bus.s_axis_tvalid[(int'(rr_ptr_q) + k) % S_COUNT]) begin
                arb_found = 1'b1;
                arb_sel   = ID_WIDTH'((int'(rr_ptr_q) + k) % S_COUNT);
            end
        end
    end

    always_comb begin
        g_keep            = bus.s_axis_tkeep[int'(grant_q)*KEEP_WIDTH +: KEEP_WIDTH];
        bus.m_axis_tdata  = bus.s_axis_tdata[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
        bus.m_axis_tkeep  = g_keep;
        bus.m_axis_tlast  = bus.s_axis_tlast[grant_q];
        bus.m_axis_tid    = grant_q;
        bus.m_axis_tvalid = (state_q == ACTIVE) && bus.s_axis_tvalid[grant_q];
        bus.s_axis_tready = '0;
        if (state_q == ACTIVE) begin
            bus.s_axis_tready[grant_q] = bus.m_axis_tready;
        end
    end

    assign beat = bus.m_axis_tvalid && bus.m_axis_tready;

    always_comb begin
        beat_bytes = '0;
        if (KEEP_ENABLE != 0) begin
            for (int b = 0; b < KEEP_WIDTH; b++) begin
                beat_bytes = beat_bytes + SUM_W'(g_keep[b]);
            end
        end else begin
            beat_bytes = SUM_W'(KEEP_WIDTH);
        end
        len_sum = SUM_W'(len_cnt_q) + beat_bytes;
        len_sat = (len_sum > LEN_MAX) ? {LEN_WIDTH{1'b1}} : len_sum[LEN_WIDTH-1:0];
    end

    always_comb begin
        state_d           = state_q;
        grant_d           = grant_q;
        rr_ptr_d          = rr_ptr_q;
        len_cnt_d         = len_cnt_q;
        frame_len_d       = frame_len_q;
        frame_len_id_d    = frame_len_id_q;
        frame_len_valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (arb_found) begin
                    grant_d = arb_sel;
                    state_d = ACTIVE;
                end
            end
            ACTIVE: begin
                if (beat) begin
                    if (bus.m_axis_tlast) begin
                        frame_len_d       = len_sat;
                        frame_len_id_d    = grant_q;
                        frame_len_valid_d = 1'b1;
                        len_cnt_d         = '0;
                        rr_ptr_d          = (int'(grant_q) == S_COUNT - 1) ? '0 : grant_q + ID_WIDTH'(1);
                        state_d           = IDLE;
                    end else begin
                        len_cnt_d = len_sat;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q           <= IDLE;
            grant_q           <= '0;
            rr_ptr_q          <= '0;
            len_cnt_q         <= '0;
            frame_len_q       <= '0;
            frame_len_id_q    <= '0;
            frame_len_valid_q <= 1'b0;
        end else begin
            state_q           <= state_d;
            grant_q           <= grant_d;
            rr_ptr_q          <= rr_ptr_d;
            len_cnt_q         <= len_cnt_d;
            frame_len_q       <= frame_len_d;
            frame_len_id_q    <= frame_len_id_d;
            frame_len_valid_q <= frame_len_valid_d;
        end
    end

    assign frame_len_o       = frame_len_q;
    assign frame_len_id_o    = frame_len_id_q;
    assign frame_len_valid_o = frame_len_valid_q;

endmodule

// File: tb/tb_axis_frame_arb_len.sv
// Directed bench for axis_frame_arb_len: byte-mode, keep-mode and saturating-length instances.
module tb_axis_frame_arb_len;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    axis_frame_arb_len_if #(.S_COUNT(4), .DATA_WIDTH(8))  ifa ();
    axis_frame_arb_len_if #(.S_COUNT(4), .DATA_WIDTH(32)) ifk ();
    axis_frame_arb_len_if #(.S_COUNT(4), .DATA_WIDTH(8))  ifs ();

    logic [15:0] fl_a, fl_k;
    logic [3:0]  fl_s;
    logic [1:0]  flid_a, flid_k, flid_s;
    logic        flv_a, flv_k, flv_s;

    axis_frame_arb_len #(.S_COUNT(4), .DATA_WIDTH(8), .KEEP_ENABLE(0), .KEEP_WIDTH(1), .LEN_WIDTH(16)) dut_a (
        .clk(clk), .rst(rst), .bus(ifa),
        .frame_len_o(fl_a), .frame_len_id_o(flid_a), .frame_len_valid_o(flv_a));

    axis_frame_arb_len #(.S_COUNT(4), .DATA_WIDTH(32), .KEEP_ENABLE(1), .KEEP_WIDTH(4), .LEN_WIDTH(16)) dut_k (
        .clk(clk), .rst(rst), .bus(ifk),
        .frame_len_o(fl_k), .frame_len_id_o(flid_k), .frame_len_valid_o(flv_k));

    axis_frame_arb_len #(.S_COUNT(4), .DATA_WIDTH(8), .KEEP_ENABLE(0), .KEEP_WIDTH(1), .LEN_WIDTH(4)) dut_s (
        .clk(clk), .rst(rst), .bus(ifs),
        .frame_len_o(fl_s), .frame_len_id_o(flid_s), .frame_len_valid_o(flv_s));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic init_inputs();
        rst = 1'b1;
        ifa.s_axis_tdata = '0; ifa.s_axis_tkeep = '1; ifa.s_axis_tvalid = '0; ifa.s_axis_tlast = '0;
        ifa.m_axis_tready = 1'b1;
        ifk.s_axis_tdata = '0; ifk.s_axis_tkeep = '0; ifk.s_axis_tvalid = '0; ifk.s_axis_tlast = '0;
        ifk.m_axis_tready = 1'b1;
        ifs.s_axis_tdata = '0; ifs.s_axis_tkeep = '1; ifs.s_axis_tvalid = '0; ifs.s_axis_tlast = '0;
        ifs.m_axis_tready = 1'b1;
    endtask

    task automatic test_reset();
        ifa.s_axis_tvalid = 4'b1111;
        #1;
        total++; if (ifa.s_axis_tready !== 4'b0000) begin bad++; $display("FAIL rst_tready: got %b want 0000", ifa.s_axis_tready); end
        total++; if (ifa.m_axis_tvalid !== 1'b0) begin bad++; $display("FAIL rst_tvalid: got %b want 0", ifa.m_axis_tvalid); end
        total++; if (fl_a !== 16'd0) begin bad++; $display("FAIL rst_frame_len: got %0d want 0", fl_a); end
        total++; if (flid_a !== 2'd0) begin bad++; $display("FAIL rst_frame_len_id: got %0d want 0", flid_a); end
        total++; if (flv_a !== 1'b0) begin bad++; $display("FAIL rst_frame_len_valid: got %b want 0", flv_a); end
        total++; if (fl_s !== 4'd0) begin bad++; $display("FAIL rst_frame_len_sat: got %0d want 0", fl_s); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        total++; if (ifa.s_axis_tready !== 4'b0000) begin bad++; $display("FAIL rel_tready: got %b want 0000", ifa.s_axis_tready); end
        total++; if (ifa.m_axis_tvalid !== 1'b0) begin bad++; $display("FAIL rel_tvalid: got %b want 0", ifa.m_axis_tvalid); end
        ifa.s_axis_tvalid = 4'b0000;
    endtask

    task automatic test_single_frame();
        @(negedge clk);
        ifa.s_axis_tvalid = 4'b0001; ifa.s_axis_tdata[7:0] = 8'hA0; ifa.s_axis_tlast = 4'b0000;
        #1;
        total++; if (ifa.m_axis_tvalid !== 1'b0) begin bad++; $display("FAIL single_idle_tvalid: got %b want 0", ifa.m_axis_tvalid); end
        for (int b = 0; b < 3; b++) begin
            @(negedge clk);
            ifa.s_axis_tdata[7:0] = 8'(8'hA0 + b);
            ifa.s_axis_tlast[0]   = (b == 2);
            #1;
            total++; if (ifa.m_axis_tvalid !== 1'b1) begin bad++; $display("FAIL single_tvalid b%0d: got %b want 1", b, ifa.m_axis_tvalid); end
            total++; if (ifa.m_axis_tid !== 2'd0) begin bad++; $display("FAIL single_tid b%0d: got %0d want 0", b, ifa.m_axis_tid); end
            total++; if (ifa.m_axis_tdata !== 8'(8'hA0 + b)) begin bad++; $display("FAIL single_tdata b%0d: got %h want %h", b, ifa.m_axis_tdata, 8'(8'hA0 + b)); end
            total++; if (ifa.s_axis_tready !== 4'b0001) begin bad++; $display("FAIL single_tready b%0d: got %b want 0001", b, ifa.s_axis_tready); end
            total++; if (flv_a !== 1'b0) begin bad++; $display("FAIL single_early_strobe b%0d: got %b want 0", b, flv_a); end
        end
        @(negedge clk);
        ifa.s_axis_tvalid = 4'b0000; ifa.s_axis_tlast = 4'b0000;
        #1;
        total++; if (flv_a !== 1'b1) begin bad++; $display("FAIL single_strobe: got %b want 1", flv_a); end
        total++; if (fl_a !== 16'd3) begin bad++; $display("FAIL single_len: got %0d want 3", fl_a); end
        total++; if (flid_a !== 2'd0) begin bad++; $display("FAIL single_id: got %0d want 0", flid_a); end
        @(negedge clk);
        #1;
        total++; if (flv_a !== 1'b0) begin bad++; $display("FAIL single_strobe_width: got %b want 0", flv_a); end
        total++; if (fl_a !== 16'd3) begin bad++; $display("FAIL single_len_hold: got %0d want 3", fl_a); end
    endtask

    task automatic test_round_robin();
        int beats [4];
        int phase;
        int frame;
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        for (int p = 0; p < 4; p++) beats[p] = 0;
        for (int c = 0; c < 13; c++) begin
            @(negedge clk);
            for (int p = 0; p < 4; p++) begin
                ifa.s_axis_tvalid[p]         = (beats[p] < 2);
                ifa.s_axis_tdata[p*8 +: 8]   = 8'(p*16 + beats[p]);
                ifa.s_axis_tlast[p]          = (beats[p] == 1);
            end
            #1;
            phase = c % 3;
            frame = c / 3;
            total++; if (ifa.m_axis_tvalid !== (phase != 0)) begin bad++; $display("FAIL rr_tvalid c%0d: got %b want %b", c, ifa.m_axis_tvalid, (phase != 0)); end
            if (phase != 0) begin
                total++; if (ifa.m_axis_tid !== 2'(frame)) begin bad++; $display("FAIL rr_tid c%0d: got %0d want %0d", c, ifa.m_axis_tid, frame); end
                total++; if (ifa.m_axis_tdata !== 8'(frame*16 + phase - 1)) begin bad++; $display("FAIL rr_tdata c%0d: got %h want %h", c, ifa.m_axis_tdata, 8'(frame*16 + phase - 1)); end
                total++; if (ifa.m_axis_tlast !== (phase == 2)) begin bad++; $display("FAIL rr_tlast c%0d: got %b want %b", c, ifa.m_axis_tlast, (phase == 2)); end
                total++; if (ifa.s_axis_tready !== 4'(1 << frame)) begin bad++; $display("FAIL rr_tready c%0d: got %b want %b", c, ifa.s_axis_tready, 4'(1 << frame)); end
            end
            total++; if (flv_a !== (phase == 0 && c > 0)) begin bad++; $display("FAIL rr_strobe c%0d: got %b want %b", c, flv_a, (phase == 0 && c > 0)); end
            if (phase == 0 && c > 0) begin
                total++; if (fl_a !== 16'd2) begin bad++; $display("FAIL rr_len c%0d: got %0d want 2", c, fl_a); end
                total++; if (flid_a !== 2'(frame - 1)) begin bad++; $display("FAIL rr_id c%0d: got %0d want %0d", c, flid_a, frame - 1); end
            end
            for (int p = 0; p < 4; p++) begin
                if (ifa.s_axis_tvalid[p] && ifa.s_axis_tready[p]) beats[p]++;
            end
        end
        ifa.s_axis_tvalid = 4'b0000; ifa.s_axis_tlast = 4'b0000;
    endtask

    task automatic test_backpressure();
        logic rdy [5];
        int   exp_b [5];
        int   b1;
        rdy   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        exp_b = '{0, 1, 1, 1, 2};
        b1 = 0;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            ifa.s_axis_tvalid[1]     = (b1 < 3);
            ifa.s_axis_tdata[15:8]   = 8'(8'h10 + b1);
            ifa.s_axis_tlast[1]      = (b1 == 2);
            ifa.s_axis_tvalid[3]     = (c < 6);
            ifa.s_axis_tdata[31:24]  = 8'h3F;
            ifa.s_axis_tlast[3]      = 1'b0;
            ifa.m_axis_tready        = (c >= 1 && c <= 5) ? rdy[c-1] : 1'b1;
            #1;
            if (c == 0) begin
                total++; if (ifa.m_axis_tvalid !== 1'b0) begin bad++; $display("FAIL bp_idle_tvalid: got %b want 0", ifa.m_axis_tvalid); end
            end else if (c <= 5) begin
                total++; if (ifa.m_axis_tid !== 2'd1) begin bad++; $display("FAIL bp_tid c%0d: got %0d want 1", c, ifa.m_axis_tid); end
                total++; if (ifa.s_axis_tready !== (rdy[c-1] ? 4'b0010 : 4'b0000)) begin bad++; $display("FAIL bp_tready c%0d: got %b want %b", c, ifa.s_axis_tready, (rdy[c-1] ? 4'b0010 : 4'b0000)); end
                total++; if (ifa.m_axis_tdata !== 8'(8'h10 + exp_b[c-1])) begin bad++; $display("FAIL bp_tdata c%0d: got %h want %h", c, ifa.m_axis_tdata, 8'(8'h10 + exp_b[c-1])); end
                total++; if (flv_a !== 1'b0) begin bad++; $display("FAIL bp_early_strobe c%0d: got %b want 0", c, flv_a); end
            end else begin
                total++; if (flv_a !== 1'b1) begin bad++; $display("FAIL bp_strobe: got %b want 1", flv_a); end
                total++; if (fl_a !== 16'd3) begin bad++; $display("FAIL bp_len: got %0d want 3", fl_a); end
                total++; if (flid_a !== 2'd1) begin bad++; $display("FAIL bp_id: got %0d want 1", flid_a); end
            end
            if (ifa.s_axis_tvalid[1] && ifa.s_axis_tready[1]) b1++;
        end
        ifa.m_axis_tready = 1'b1; ifa.s_axis_tlast = 4'b0000;
    endtask

    task automatic test_keep_bytes();
        logic [3:0] keeps [2][3];
        int         nbeats [2];
        int         port [2];
        int         exp_len [2];
        keeps   = '{'{4'hF, 4'hF, 4'h3}, '{4'h7, 4'h0, 4'h0}};
        nbeats  = '{3, 2};
        port    = '{2, 0};
        exp_len = '{10, 3};
        for (int f = 0; f < 2; f++) begin
            @(negedge clk);
            ifk.s_axis_tvalid[port[f]] = 1'b1;
            ifk.s_axis_tkeep[port[f]*4 +: 4] = keeps[f][0];
            ifk.s_axis_tlast[port[f]]  = 1'b0;
            #1;
            total++; if (ifk.m_axis_tvalid !== 1'b0) begin bad++; $display("FAIL keep_idle f%0d: got %b want 0", f, ifk.m_axis_tvalid); end
            for (int b = 0; b < nbeats[f]; b++) begin
                @(negedge clk);
                ifk.s_axis_tkeep[port[f]*4 +: 4]  = keeps[f][b];
                ifk.s_axis_tdata[port[f]*32 +: 32] = 32'(b);
                ifk.s_axis_tlast[port[f]]         = (b == nbeats[f] - 1);
                #1;
                total++; if (ifk.m_axis_tid !== 2'(port[f])) begin bad++; $display("FAIL keep_tid f%0d b%0d: got %0d want %0d", f, b, ifk.m_axis_tid, port[f]); end
                total++; if (ifk.m_axis_tkeep !== keeps[f][b]) begin bad++; $display("FAIL keep_tkeep f%0d b%0d: got %b want %b", f, b, ifk.m_axis_tkeep, keeps[f][b]); end
                total++; if (ifk.m_axis_tvalid !== 1'b1) begin bad++; $display("FAIL keep_tvalid f%0d b%0d: got %b want 1", f, b, ifk.m_axis_tvalid); end
            end
            @(negedge clk);
            ifk.s_axis_tvalid = 4'b0000; ifk.s_axis_tlast = 4'b0000;
            #1;
            total++; if (flv_k !== 1'b1) begin bad++; $display("FAIL keep_strobe f%0d: got %b want 1", f, flv_k); end
            total++; if (fl_k !== 16'(exp_len[f])) begin bad++; $display("FAIL keep_len f%0d: got %0d want %0d", f, fl_k, exp_len[f]); end
            total++; if (flid_k !== 2'(port[f])) begin bad++; $display("FAIL keep_id f%0d: got %0d want %0d", f, flid_k, port[f]); end
        end
    endtask

    task automatic test_saturation();
        int nbeats [2];
        int exp_len [2];
        nbeats  = '{14, 20};
        exp_len = '{14, 15};
        for (int f = 0; f < 2; f++) begin
            @(negedge clk);
            ifs.s_axis_tvalid = 4'b0001; ifs.s_axis_tlast = 4'b0000;
            #1;
            total++; if (ifs.m_axis_tvalid !== 1'b0) begin bad++; $display("FAIL sat_idle f%0d: got %b want 0", f, ifs.m_axis_tvalid); end
            for (int b = 0; b < nbeats[f]; b++) begin
                @(negedge clk);
                ifs.s_axis_tdata[7:0] = 8'(b);
                ifs.s_axis_tlast[0]   = (b == nbeats[f] - 1);
                #1;
                total++; if (ifs.m_axis_tvalid !== 1'b1 || flv_s !== 1'b0) begin bad++; $display("FAIL sat_beat f%0d b%0d: got tvalid=%b strobe=%b want 1/0", f, b, ifs.m_axis_tvalid, flv_s); end
            end
            @(negedge clk);
            ifs.s_axis_tvalid = 4'b0000; ifs.s_axis_tlast = 4'b0000;
            #1;
            total++; if (flv_s !== 1'b1) begin bad++; $display("FAIL sat_strobe f%0d: got %b want 1", f, flv_s); end
            total++; if (fl_s !== 4'(exp_len[f])) begin bad++; $display("FAIL sat_len f%0d: got %0d want %0d", f, fl_s, exp_len[f]); end
        end
    endtask

    task automatic test_reset_midframe();
        @(negedge clk);
        ifa.s_axis_tvalid = 4'b0001; ifa.s_axis_tlast = 4'b0000; ifa.s_axis_tdata[7:0] = 8'h00;
        for (int b = 0; b < 2; b++) begin
            @(negedge clk);
            ifa.s_axis_tdata[7:0] = 8'(b);
            #1;
            total++; if (ifa.m_axis_tvalid !== 1'b1 || ifa.m_axis_tid !== 2'd0) begin bad++; $display("FAIL mid_beat b%0d: got tvalid=%b tid=%0d want 1/0", b, ifa.m_axis_tvalid, ifa.m_axis_tid); end
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        total++; if (ifa.s_axis_tready !== 4'b0000) begin bad++; $display("FAIL mid_rst_tready: got %b want 0000", ifa.s_axis_tready); end
        total++; if (ifa.m_axis_tvalid !== 1'b0) begin bad++; $display("FAIL mid_rst_tvalid: got %b want 0", ifa.m_axis_tvalid); end
        total++; if (fl_a !== 16'd0) begin bad++; $display("FAIL mid_rst_len: got %0d want 0", fl_a); end
        total++; if (flv_a !== 1'b0) begin bad++; $display("FAIL mid_rst_strobe: got %b want 0", flv_a); end
        @(negedge clk);
        rst = 1'b0;
        ifa.s_axis_tvalid = 4'b0000;
        #1;
        total++; if (ifa.m_axis_tvalid !== 1'b0 || flv_a !== 1'b0) begin bad++; $display("FAIL mid_release: got tvalid=%b strobe=%b want 0/0", ifa.m_axis_tvalid, flv_a); end
        @(negedge clk);
        ifa.s_axis_tvalid = 4'b0100; ifa.s_axis_tlast = 4'b0100; ifa.s_axis_tdata[23:16] = 8'h5A;
        #1;
        total++; if (ifa.m_axis_tvalid !== 1'b0) begin bad++; $display("FAIL mid_p2_idle: got %b want 0", ifa.m_axis_tvalid); end
        @(negedge clk);
        #1;
        total++; if (ifa.m_axis_tid !== 2'd2) begin bad++; $display("FAIL mid_p2_tid: got %0d want 2", ifa.m_axis_tid); end
        total++; if (ifa.m_axis_tdata !== 8'h5A) begin bad++; $display("FAIL mid_p2_tdata: got %h want 5a", ifa.m_axis_tdata); end
        @(negedge clk);
        ifa.s_axis_tvalid = 4'b0000; ifa.s_axis_tlast = 4'b0000;
        #1;
        total++; if (flv_a !== 1'b1) begin bad++; $display("FAIL mid_p2_strobe: got %b want 1", flv_a); end
        total++; if (fl_a !== 16'd1) begin bad++; $display("FAIL mid_p2_len: got %0d want 1", fl_a); end
        total++; if (flid_a !== 2'd2) begin bad++; $display("FAIL mid_p2_id: got %0d want 2", flid_a); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        init_inputs();
        test_reset();
        test_single_frame();
        test_round_robin();
        test_backpressure();
        test_keep_bytes();
        test_saturation();
        test_reset_midframe();
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
